// File: rtl/axil_gp_master.sv
// ---------------------------------------------------------------------------
// axil_gp_master
//   Turns a simple command/response request pair into single AXI4-Lite
//   read or write transfers. Only one transaction is ever in flight.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   cmd_valid/ready/we/addr/wdata   command channel (accepted in IDLE only)
//   rsp_valid/ready/rdata/resp      response channel (rdata is 0 for writes)
//   m_axi_aw* / m_axi_w* / m_axi_b* AXI4-Lite write address/data/response
//   m_axi_ar* / m_axi_r*            AXI4-Lite read address/data
// ---------------------------------------------------------------------------
module axil_gp_master #(
    parameter int C_S_AXI_GP_DATA_WIDTH = 32,
    parameter int C_S_AXI_GP_ADDR_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_we,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   cmd_wdata,

    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                         rsp_resp,

    output logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                         m_axi_awprot,
    output logic                               m_axi_awvalid,
    input  logic                               m_axi_awready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                               m_axi_wvalid,
    input  logic                               m_axi_wready,
    input  logic [1:0]                         m_axi_bresp,
    input  logic                               m_axi_bvalid,
    output logic                               m_axi_bready,

    output logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                         m_axi_arprot,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                         m_axi_rresp,
    input  logic                               m_axi_rvalid,
    output logic                               m_axi_rready
);

    localparam int DW = C_S_AXI_GP_DATA_WIDTH;
    localparam int AW = C_S_AXI_GP_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t          r_state;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic [1:0]      r_rsp_resp;
    logic [AW-1:0]   r_awaddr;
    logic            r_awvalid;
    logic [DW-1:0]   r_wdata;
    logic            r_wvalid;
    logic            r_bready;
    logic [AW-1:0]   r_araddr;
    logic            r_arvalid;
    logic            r_rready;

    // AW/W valids are raised on entry to WR_REQ and dropped on their own
    // handshake, so a low valid inside WR_REQ means that channel is done.
    logic w_aw_ok;
    logic w_w_ok;
    assign w_aw_ok = ~r_awvalid | m_axi_awready;
    assign w_w_ok  = ~r_wvalid  | m_axi_wready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_we) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_gp_master.sv
// ---------------------------------------------------------------------------
// tb_axil_gp_master
//   Directed bench for axil_gp_master: the bench plays the AXI-Lite slave
//   cycle by cycle and checks master outputs 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_axil_gp_master;

    localparam int DW = 32;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
    logic            arvalid, arready, rvalid, rready;

    always #5 clk = ~clk;

    axil_gp_master #(.C_S_AXI_GP_DATA_WIDTH(DW), .C_S_AXI_GP_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // handshake counters, sampled on the active edge
    int aw_hs = 0, w_hs = 0, b_hs = 0, rsp_hs = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (awvalid && awready)     aw_hs  <= aw_hs + 1;
            if (wvalid && wready)       w_hs   <= w_hs + 1;
            if (bvalid && bready)       b_hs   <= b_hs + 1;
            if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a command for exactly one accepting edge
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    int aw0, w0, b0, r0;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (2) tick();

        // ---- reset state
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_addrs", {awaddr, araddr}, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rsp_data", {rsp_rdata, rsp_resp}, 0);
        rst = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("prot_strb", {awprot, arprot, wstrb}, 10'h00F);

        // ---- write, AW and W accepted on the same edge
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        issue(1'b1, 4'h4, 32'hDEADBEEF);
        chk("w1_cmd_ready", cmd_ready, 0);
        chk("w1_valids", {awvalid, wvalid}, 2'b11);
        chk("w1_awaddr", awaddr, 4'h4);
        chk("w1_wdata", wdata, 32'hDEADBEEF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("w1_valids_drop", {awvalid, wvalid}, 2'b00);
        chk("w1_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("w1_rsp_valid", rsp_valid, 1);
        chk("w1_rsp_resp", rsp_resp, 2'b00);
        chk("w1_rsp_rdata", rsp_rdata, 0);
        chk("w1_bready_off", bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_idle_cmd_ready", cmd_ready, 1);
        chk("w1_idle_rsp_valid", rsp_valid, 0);
        chk("w1_hs_counts", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});

        // ---- write, W accepted 3 cycles before AW, late B held longer
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        issue(1'b1, 4'hC, 32'h12345678);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("w2_wvalid_drop", wvalid, 0);
        chk("w2_awvalid_hold0", awvalid, 1);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("w2_awvalid_hold", {awvalid, wvalid, bready}, 3'b100);
            chk("w2_awaddr_stable", awaddr, 4'hC);
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("w2_awvalid_drop", awvalid, 0);
        chk("w2_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b11;
        tick();
        chk("w2_rsp", {rsp_valid, rsp_resp}, 3'b111);
        rsp_ready = 1'b1;
        tick();
        bvalid = 1'b0; rsp_ready = 1'b0;
        chk("w2_hs_counts", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        chk("w2_cmd_ready", cmd_ready, 1);

        // ---- read addr 8, five cycles of rvalid wait, then held response
        issue(1'b0, 4'h8, 32'h0);
        chk("r1_arvalid", arvalid, 1);
        chk("r1_araddr", araddr, 4'h8);
        chk("r1_no_write", {awvalid, wvalid}, 2'b00);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r1_arvalid_drop", arvalid, 0);
        chk("r1_rready", rready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r1_wait", {rready, rsp_valid}, 2'b10);
        end
        rvalid = 1'b1; rdata = 32'h0000_00A5; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b11;
        chk("r1_rsp_valid", rsp_valid, 1);
        chk("r1_rsp_rdata", rsp_rdata, 32'h0000_00A5);
        chk("r1_rsp_resp", rsp_resp, 2'b00);
        chk("r1_rready_off", rready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r1_hold", {rsp_valid, cmd_ready, rsp_resp}, 4'b1000);
            chk("r1_hold_rdata", rsp_rdata, 32'h0000_00A5);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("r1_release", {rsp_valid, cmd_ready}, 2'b01);

        // ---- read answered with SLVERR, zero-wait slave
        issue(1'b0, 4'h2, 32'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFF_0000; rresp = 2'b10;
        tick();
        rvalid = 1'b0;
        chk("r2_rsp", {rsp_valid, rsp_resp}, 3'b110);
        chk("r2_rdata", rsp_rdata, 32'hFFFF_0000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- stray B/R while idle must not be accepted
        b0 = b_hs;
        bvalid = 1'b1; rvalid = 1'b1;
        tick();
        chk("stray_ready", {bready, rready, rsp_valid}, 3'b000);
        bvalid = 1'b0; rvalid = 1'b0;
        chk("stray_b_hs", b_hs - b0, 0);

        // ---- reset while awvalid high
        r0 = rsp_hs;
        issue(1'b1, 4'h6, 32'hCAFEF00D);
        chk("rw_awvalid", awvalid, 1);
        rst = 1'b0;
        tick();
        chk("rw_abandon", {awvalid, wvalid, rsp_valid, bready}, 4'b0000);
        chk("rw_awaddr_clr", awaddr, 0);
        rst = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        tick();
        chk("rw_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_rsp", {rsp_valid, awvalid, bready}, 3'b000);
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        chk("rw_rsp_count", rsp_hs - r0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axil_gp_master.md
AXIL_GP_MASTER -- requirements
Module: axil_gp_master

Interface
REQ-001 SHALL have parameter C_S_AXI_GP_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter C_S_AXI_GP_ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_we  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  ADDR_WIDTH  register byte address.
REQ-009 cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-013 rsp_resp  out  2  BRESP/RRESP of the completed transfer.
REQ-014 m_axi_awaddr  out  ADDR_WIDTH  write address.
REQ-015 m_axi_awprot  out  3  constant 3'b000.
REQ-016 m_axi_awvalid  out  1  write address valid.
REQ-017 m_axi_awready  in  1  write address ready.
REQ-018 m_axi_wdata  out  DATA_WIDTH  write data.
REQ-019 m_axi_wstrb  out  DATA_WIDTH/8  constant all ones.
REQ-020 m_axi_wvalid  out  1  write data valid.
REQ-021 m_axi_wready  in  1  write data ready.
REQ-022 m_axi_bresp  in  2  write response.
REQ-023 m_axi_bvalid  in  1  write response valid.
REQ-024 m_axi_bready  out  1  write response ready.
REQ-025 m_axi_araddr  out  ADDR_WIDTH  read address.
REQ-026 m_axi_arprot  out  3  constant 3'b000.
REQ-027 m_axi_arvalid  out  1  read address valid.
REQ-028 m_axi_arready  in  1  read address ready.
REQ-029 m_axi_rdata  in  DATA_WIDTH  read data.
REQ-030 m_axi_rresp  in  2  read response.
REQ-031 m_axi_rvalid  in  1  read data valid.
REQ-032 m_axi_rready  out  1  read data ready.

Function
REQ-033 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one outstanding transaction maximum.
REQ-034 cmd_ready SHALL be high only in IDLE; on cmd_valid&cmd_ready, SHALL register addr/wdata/we and go to WR_REQ (we=1) or RD_REQ (we=0).
REQ-035 WR_REQ: awvalid and wvalid SHALL assert in the first WR_REQ cycle, each held until its own handshake, deasserting the cycle after; AW and W may complete in either order or the same cycle.
REQ-036 After both AW and W handshakes, SHALL enter WR_RESP with bready=1; on bvalid, SHALL capture bresp, set rsp_rdata=0, go to RSP.
REQ-037 RD_REQ: arvalid SHALL hold until arready, then go to RD_DATA with rready=1; on rvalid, SHALL capture rdata/rresp, go to RSP.
REQ-038 bready/rready SHALL be low outside WR_RESP/RD_DATA; bvalid/rvalid arriving elsewhere SHALL be ignored.
REQ-039 AXI address/data outputs SHALL stay stable while the corresponding valid is high.
REQ-040 RSP: rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready; then IDLE next cycle.
REQ-041 Minimum latency, zero-wait slave: write accept-to-rsp_valid 3 cycles, read 3 cycles; rsp_ready high yields next cmd_ready 1 cycle after RSP.
REQ-042 SLVERR/DECERR SHALL be passed on rsp_resp unchanged; no retry.

Reset
REQ-043 When rst=0 at a rising edge: state IDLE; all valid/ready outputs 0 except cmd_ready=1 after release; awaddr/araddr/wdata/rsp_rdata/rsp_resp 0.
REQ-044 Reset mid-transaction SHALL abandon it immediately; no rsp_valid for the abandoned command.

Verification
REQ-045 Write addr 4'h4 data 32'hDEADBEEF, slave awready/wready same cycle, bresp=00 -> one AW and one W handshake, rsp_valid with rsp_resp=00, rsp_rdata=0.
REQ-046 Write with wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held, single B accepted.
REQ-047 Read addr 4'h8, slave returns 32'h0000_00A5 after 5 rvalid-wait cycles -> rsp_rdata=32'h0000_00A5, rsp_resp=00.
REQ-048 Read answered with rresp=2'b10 -> rsp_resp=2'b10 propagated.
REQ-049 rsp_ready held low 4 cycles -> rsp outputs stable, cmd_ready low throughout.
REQ-050 rst=0 asserted while awvalid high -> awvalid 0 next cycle, no rsp_valid, cmd_ready=1 after release.
